pipe_addsub_unit: RTL

//   Parametrised, pipelined signed add/subtract unit with valid/ready flow control on input and output.

---
 rtl/pipe_addsub_unit_if.sv | 28 ++
 rtl/pipe_addsub_unit.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipe_addsub_unit_if.sv
// Operand/result handshake bundle for pipe_addsub_unit: producer side drives
// operands, consumer side drives out_ready and receives result, flags and count.
interface pipe_addsub_unit_if #(
  parameter int W     = 20,
  parameter int CNT_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic                op;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] y;
  logic                cout;
  logic                ovf;
  logic [CNT_W-1:0]    txn_cnt;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, cout, ovf, txn_cnt
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, cout, ovf, txn_cnt
  );
endinterface

// File: rtl/pipe_addsub_unit.sv
// Pipelined signed add/subtract with valid/ready on both sides, carry/overflow
// flags and a transaction counter. Define PIPE_ADDSUB_SAT_EN to saturate y on overflow.
module pipe_addsub_unit #(
  parameter int W      = 20,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_addsub_unit_if.slave  bus
);

  if (STAGES < 1 || STAGES > 4 || W < 2) begin : g_bad_params
    $error("pipe_addsub_unit: STAGES must be 1..4 and W >= 2");
  end

  // W+1-bit signed result; bit W is the true sign, used for overflow detection.
  function automatic logic signed [W:0] add_sub(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] z,
                                                input logic op_sub);
    logic signed [W:0] xe;
    logic signed [W:0] ze;
    xe = x;
    ze = z;
    return op_sub ? (xe - ze) : (xe + ze);
  endfunction

  function automatic logic carry_out(input logic [W-1:0] x,
                                     input logic [W-1:0] z,
                                     input logic op_sub);
    logic [W-1:0] zz;
    zz = op_sub ? ~z : z;
    return 1'(({1'b0, x} + {1'b0, zz} + {{W{1'b0}}, op_sub}) >> W);
  endfunction

`ifdef PIPE_ADDSUB_SAT_EN
  function automatic logic signed [W-1:0] saturate(input logic signed [W:0] s);
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction
`endif

  logic signed [W:0]   sum_c;
  logic signed [W-1:0] y_c;
  logic                cout_c;
  logic                ovf_c;

  always_comb begin
    sum_c  = add_sub(bus.a, bus.b, bus.op);
    cout_c = carry_out(bus.a, bus.b, bus.op);
    ovf_c  = sum_c[W] ^ sum_c[W-1];
`ifdef PIPE_ADDSUB_SAT_EN
    y_c    = saturate(sum_c);
`else
    y_c    = sum_c[W-1:0];
`endif
  end

  logic [STAGES:1]     vld_p;
  logic signed [W-1:0] y_p    [1:STAGES];
  logic                cout_p [1:STAGES];
  logic                ovf_p  [1:STAGES];
  logic [STAGES:1]     adv;
  logic [CNT_W-1:0]    txn_q;

  // Stage k may advance when it, or any stage after it, has a free slot, or the consumer takes.
  always_comb begin
    logic any_empty;
    any_empty = 1'b0;
    adv       = '0;
    for (int k = STAGES; k >= 1; k--) begin
      any_empty = any_empty | ~vld_p[k];
      adv[k]    = bus.out_ready | any_empty;
    end
  end

  assign bus.in_ready  = adv[1];
  assign bus.out_valid = vld_p[STAGES];
  assign bus.y         = y_p[STAGES];
  assign bus.cout      = cout_p[STAGES];
  assign bus.ovf       = ovf_p[STAGES];
  assign bus.txn_cnt   = txn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      txn_q <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        y_p[k]    <= '0;
        cout_p[k] <= 1'b0;
        ovf_p[k]  <= 1'b0;
      end
    end else begin
      // stage 1: capture the combinational result of the accepted operation
      if (adv[1]) begin
        vld_p[1]  <= bus.in_valid;
        y_p[1]    <= y_c;
        cout_p[1] <= cout_c;
        ovf_p[1]  <= ovf_c;
      end
      // stages 2..STAGES: shift forward only into a slot that is free or draining
      for (int k = 2; k <= STAGES; k++) begin
        if (adv[k]) begin
          vld_p[k]  <= vld_p[k-1];
          y_p[k]    <= y_p[k-1];
          cout_p[k] <= cout_p[k-1];
          ovf_p[k]  <= ovf_p[k-1];
        end
      end
      if (vld_p[STAGES] && bus.out_ready)
        txn_q <= txn_q + 1'b1;
    end
  end

endmodule
